// File: rtl/fa_bist_pkg.sv
// Shared types and the full-adder reference used by the fa_bist_engine self-test.
package fa_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // Golden full-adder response for input vector {a,b,c}, returned as {sum,carry}.
    function automatic logic [1:0] fa_expect(input logic [2:0] v);
        logic s_v;
        logic co_v;
        s_v  = v[2] ^ v[1] ^ v[0];
        co_v = (v[2] & v[1]) | (v[1] & v[0]) | (v[0] & v[2]);
        return {s_v, co_v};
    endfunction

endpackage

// File: rtl/fa_bist_engine.sv
// On-chip self-test for a full adder: walks all eight {a,b,c} vectors,
// compares sum/carry against the reference and reports pass, error count and first failure.
module fa_bist_engine
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 sum,
    input  logic                 carry,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [2:0]           first_fail
);

    localparam int                   CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

    state_t                 state_r, state_s;
    logic [2:0]             vec_r, vec_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   pass_r, pass_s;
    logic [ERR_CNT_W-1:0]   err_r, err_s;
    logic [2:0]             ff_r, ff_s;
    logic                   seen_r, seen_s;
    logic                   mis_s;

    // The driven vector doubles as {a,b,c}; it is already a register.
    assign a          = vec_r[2];
    assign b          = vec_r[1];
    assign c          = vec_r[0];
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign first_fail = ff_r;

    // Next-state and next-output logic; busy/done are precomputed so the outputs stay registered.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        ff_s    = ff_r;
        seen_s  = seen_r;
        pass_s  = pass_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        mis_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = WAIT;
                    vec_s   = 3'd0;
                    cnt_s   = '0;
                    err_s   = '0;
                    ff_s    = 3'd0;
                    seen_s  = 1'b0;
                    pass_s  = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                busy_s = 1'b1;
                if (cnt_r == SETTLE_LAST) begin
                    state_s = CHECK;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            CHECK: begin
                // !== so that an unknown response is flagged rather than silently matching.
                mis_s = ({sum, carry} !== fa_expect(vec_r));
                if (mis_s) begin
                    seen_s = 1'b1;
                    if (err_r == ERR_MAX) begin
                        err_s = err_r;
                    end else begin
                        err_s = err_r + ERR_CNT_W'(1);
                    end
                    if (!seen_r) begin
                        ff_s = vec_r;
                    end else begin
                        ff_s = ff_r;
                    end
                end else begin
                    seen_s = seen_r;
                end
                if (vec_r == VEC_LAST) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    pass_s  = !(seen_r || mis_s);
                end else begin
                    state_s = WAIT;
                    vec_s   = vec_r + 3'd1;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            vec_r   <= 3'd0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= '0;
            ff_r    <= 3'd0;
            seen_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            ff_r    <= ff_s;
            seen_r  <= seen_s;
        end
    end

endmodule

// File: tb/tb_fa_bist_engine.sv
// Bench for fa_bist_engine: two instances (SETTLE=1/W=4 and SETTLE=3/W=2) face a bench-side
// full adder with selectable faults and latency, checked every cycle against a run-level model.
module tb_fa_bist_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       pass_v [2];
    logic [3:0] err_v [2];
    logic [2:0] ff_v [2];
    logic [2:0] abc_v [2];
    int         fault_v [2];  // 0 good, 1 carry stuck-0, 2 sum inverted, 3 random corruption
    int         lat_v [2];    // output latency of the bench adder, 0..2 cycles
    logic [1:0] noise_v [2];
    int         n_checks = 0;
    int         n_fail = 0;
    bit         armed = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S    = (g == 0) ? 1 : 3;
        localparam int W    = (g == 0) ? 4 : 2;
        localparam int T    = 8 * (S + 1);
        localparam int MAXE = (1 << W) - 1;

        logic [W-1:0] err_s;
        logic         a_s, b_s, c_s, sum_s, carry_s;
        logic [2:0]   p1 = 3'd0;
        logic [2:0]   p2 = 3'd0;
        logic [2:0]   src_s;
        logic [1:0]   tot_s;

        fa_bist_engine #(.SETTLE_CYCLES(S), .ERR_CNT_W(W)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]),
            .a(a_s), .b(b_s), .c(c_s), .sum(sum_s), .carry(carry_s),
            .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]),
            .err_count(err_s), .first_fail(ff_v[g])
        );
        assign err_v[g] = 4'(err_s);
        assign abc_v[g] = {a_s, b_s, c_s};

        // Bench adder: arithmetic sum of the three bits, optionally delayed and corrupted.
        always @(posedge clk) begin
            p1 <= {a_s, b_s, c_s};
            p2 <= p1;
        end
        assign src_s   = (lat_v[g] == 0) ? {a_s, b_s, c_s} : ((lat_v[g] == 1) ? p1 : p2);
        assign tot_s   = 2'(src_s[2]) + 2'(src_s[1]) + 2'(src_s[0]);
        assign sum_s   = tot_s[0] ^ (fault_v[g] == 2) ^ ((fault_v[g] == 3) & noise_v[g][0]);
        assign carry_s = (fault_v[g] == 1) ? 1'b0 : (tot_s[1] ^ ((fault_v[g] == 3) & noise_v[g][1]));

        // Model: n = edges since the start-sampling edge, -1 when idle.
        int         n = -1;
        int         mis = 0;
        int         k, ones;
        logic [2:0] ffm = 3'd0;
        logic       pm = 1'b0;
        logic       ran = 1'b0;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n = -1; mis = 0; ffm = 3'd0; pm = 1'b0; ran = 1'b0;
            end else if (n == -1 || n == T + 1) begin
                if (start_v[g]) begin
                    n = 0; mis = 0; ffm = 3'd0; pm = 1'b0; ran = 1'b1;
                end else begin
                    n = -1;
                end
            end else begin
                n = n + 1;
                if (n % (S + 1) == 0) begin
                    k    = n / (S + 1) - 1;
                    ones = $countones(3'(k));
                    if ({sum_s, carry_s} !== {1'(ones % 2), 1'(ones / 2)}) begin
                        if (mis == 0) ffm = 3'(k);
                        mis = mis + 1;
                    end
                end
                if (n == T) pm = (mis == 0);
            end
        end

        logic [2:0]  exp_abc;
        logic [12:0] act, expv;
        always @(negedge clk) begin
            if (armed) begin
                exp_abc = (n >= 0 && n < T) ? 3'(n / (S + 1)) : (ran ? 3'd7 : 3'd0);
                expv = {exp_abc, 1'(n >= 0 && n < T), 1'(n == T), pm,
                        4'((mis > MAXE) ? MAXE : mis), ffm};
                act  = {abc_v[g], busy_v[g], done_v[g], pass_v[g], err_v[g], ff_v[g]};
                n_checks++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL cycle_compare inst%0d t=%0t: got abc,busy,done,pass,err,ff=%b required %b",
                             g, $time, act, expv);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Start a run on instance i (optionally re-pulsing start mid-run) and return the done edge.
    task automatic run(input int i, input int pulse_at, output int edges);
        edges = -1;
        start_v[i] = 1'b1;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk); #1;
            if (e == 0) start_v[i] = 1'b0;
            if (pulse_at > 0 && e == pulse_at) start_v[i] = 1'b1;
            if (pulse_at > 0 && e == pulse_at + 1) start_v[i] = 1'b0;
            if (done_v[i]) begin
                edges = e;
                break;
            end
        end
        if (edges < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout inst%0d: got no done required done", i);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            noise_v[0] = 2'($urandom);
            noise_v[1] = 2'($urandom);
        end
    end

    initial begin
        int ed, d1, d2, hit, inst;
        start_v = '{1'b0, 1'b0};
        fault_v = '{0, 0};
        lat_v   = '{0, 0};
        noise_v = '{2'd0, 2'd0};
        repeat (2) @(posedge clk);
        #1 armed = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs", {abc_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], ff_v[0]}, 0);

        run(0, -1, ed);
        chk("good_done_edge", ed, 16);
        chk("good_pass", pass_v[0], 1);
        chk("good_err", err_v[0], 0);
        chk("good_first_fail", ff_v[0], 0);
        chk("good_abc_hold", abc_v[0], 7);

        fault_v[0] = 1;
        run(0, 5, ed);
        chk("stuck_done_edge", ed, 16);
        chk("stuck_pass", pass_v[0], 0);
        chk("stuck_err", err_v[0], 4);
        chk("stuck_first_fail", ff_v[0], 3);

        fault_v[1] = 2;
        run(1, -1, ed);
        chk("inv_done_edge", ed, 32);
        chk("inv_err_sat", err_v[1], 3);
        chk("inv_first_fail", ff_v[1], 0);
        chk("inv_pass", pass_v[1], 0);

        fault_v[1] = 0; lat_v[1] = 2;
        run(1, -1, ed);
        chk("lat_s3_pass", pass_v[1], 1);
        chk("lat_s3_done_edge", ed, 32);
        fault_v[0] = 0; lat_v[0] = 2;
        run(0, -1, ed);
        chk("lat_s1_pass", pass_v[0], 0);

        lat_v[0] = 0; fault_v[0] = 1;
        hit = 0;
        start_v[0] = 1'b1;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk); #1;
            if (e == 0) start_v[0] = 1'b0;
            if (abc_v[0] == 3'd4) begin
                hit = 1;
                break;
            end
        end
        chk("reach_vec4", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_run", {abc_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], ff_v[0]}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fault_v[0] = 0;
        @(posedge clk); #1;
        run(0, -1, ed);
        chk("post_reset_pass", pass_v[0], 1);
        chk("post_reset_edge", ed, 16);

        d1 = -1; d2 = -1;
        start_v[0] = 1'b1;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk); #1;
            if (done_v[0] && d1 < 0) d1 = e;
            else if (done_v[0] && d2 < 0) d2 = e;
        end
        start_v[0] = 1'b0;
        chk("b2b_first_done", d1, 16);
        chk("b2b_period", d2 - d1, 18);
        repeat (40) @(posedge clk);
        #1;

        for (int r = 0; r < 10; r++) begin
            inst = int'($urandom_range(0, 1));
            fault_v[inst] = int'($urandom_range(0, 3));
            lat_v[inst]   = int'($urandom_range(0, 2));
            run(inst, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1, ed);
            chk("rand_done_edge", ed, (inst == 0) ? 16 : 32);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
